i2c_slave_rx: RTL and testbench
===============================

Name: i2c_slave_rx

Overview:
- Parametrised, fully synchronous I2C slave receiver. Successor to the asynchronous 16-bit SDA/SCL front end.
- Oversamples SDA/SCL on a system clock and detects START, repeated START and STOP.
- Matches a parametrised 7-bit address, ACKs the address and each data byte, and accepts 1..NBYTES data bytes per frame.
- Presents the frame to the register bank as a parallel word with a one-cycle valid strobe.

Parameters:
- SLAVE_ADDR, 7'h53, 7-bit slave address matched against the first byte [7:1].
- NBYTES, 2, maximum data bytes captured per frame (1..16).
- SYNC_STAGES, 2, synchroniser flops on SCL_IN/SDA_IN (>=2).

Ports:
- CLK  in  1  system clock; period <= 1/10 of min SCL high/low time.
- RSTN  in  1  asynchronous active-low reset.
- SCL_IN  in  1  raw I2C clock from pad.
- SDA_IN  in  1  raw I2C data from pad.
- SDA_OE  out  1  1 = pull SDA low (open-drain ACK drive).
- RX_DATA  out  8*NBYTES  captured data; byte k at [8k+7:8k], byte 0 first received.
- RX_COUNT  out  $clog2(NBYTES+1)  number of bytes in RX_DATA.
- RX_VALID  out  1  one-CLK pulse when a frame is committed.
- START_DET  out  1  one-CLK pulse per START or repeated START.
- STOP_DET  out  1  one-CLK pulse per STOP.
- BUSY  out  1  high from START to STOP.
- OVERFLOW  out  1  sticky; set when a byte beyond NBYTES is offered; cleared at next START.

Behaviour:
- Reset (RSTN=0, async): every output is 0, FSM=IDLE, shift register and byte buffer are 0, synchronisers are preset to 1 (bus idle).
- Synchronisation: SCL_IN/SDA_IN pass through SYNC_STAGES flops. Edges are detected by comparison with the previous synced value.
- START: synced SDA falls while synced SCL = 1 → START_DET pulse, BUSY=1, bit count=0, byte count=0, OVERFLOW=0, state=ADDR. Valid from any state, including mid-byte, which is a repeated START.
- Repeated START: uncommitted bytes are discarded. RX_DATA/RX_COUNT are not updated.
- STOP: synced SDA rises while synced SCL = 1 → STOP_DET pulse, BUSY=0, SDA_OE=0, state=IDLE.
  - Commit on STOP only if the address matched with W=0 and byte count >= 1.
  - On commit, in the same cycle: RX_DATA = buffer with unreceived bytes zero, RX_COUNT = byte count, RX_VALID = 1 for one cycle.
  - Commit latency: SYNC_STAGES+1 CLK cycles after the SDA rise at the pin.
- Bit sampling: on the synced SCL rising edge, SDA is shifted MSB-first into an 8-bit shift register. The bit counter is 0..7, and the 8th bit completes the byte.
- FSM states: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
  - ADDR → ADDR_ACK if byte[7:1]==SLAVE_ADDR and byte[0]==0.
  - ADDR → IGNORE otherwise: wrong address, or read (R/W=1) because this block is receive-only. Result is a NACK.
  - ADDR_ACK: SDA_OE=1 from the SCL fall after bit 8 until the next SCL fall, then → DATA.
  - DATA, byte complete:
    - byte count < NBYTES: store byte at index byte count, increment byte count, → DATA_ACK with ACK driven.
    - otherwise: OVERFLOW=1, → IGNORE with no ACK; the first NBYTES bytes are retained.
  - DATA_ACK: same drive window as ADDR_ACK, then → DATA.
  - IGNORE: SDA_OE held 0; leave only on START or STOP.
- SDA_OE changes only on synced SCL falling edges. Exceptions: STOP or START force it to 0 immediately.
- Simultaneous events: START/STOP have priority over bit sampling in the same cycle. SDA edges while SCL=0 are data transitions, not conditions.
- Glitch-free inputs are required; no filter beyond the synchronisers.
- RSTN asserted mid-frame aborts silently with no RX_VALID. After release the block waits in IDLE for the next START.

Test Plan:
- NBYTES=2: START, 0xA6, 0x12, 0x34, STOP → SDA_OE low during all three ACK bits; RX_VALID one cycle; RX_DATA=16'h3412; RX_COUNT=2; STOP_DET pulse; BUSY back to 0.
- Wrong address: START, 0xA8, 0x55, STOP → SDA_OE never 1, no RX_VALID, RX_DATA unchanged, START_DET/STOP_DET still pulse.
- Read request: START, 0xA7, STOP → NACK (SDA_OE=0 at 9th clock), no RX_VALID.
- Overflow: START, 0xA6, 0x01, 0x02, 0x03, STOP → first two bytes ACKed, third NACKed, OVERFLOW=1, RX_DATA=16'h0201, RX_COUNT=2; next START clears OVERFLOW.
- Repeated START: START, 0xA6, 0xAA, START, 0xA6, 0x5C, STOP → two START_DET pulses, single RX_VALID, RX_DATA=16'h005C, RX_COUNT=1.
- Reset mid-frame: RSTN low during 4th data bit → all outputs 0 immediately; following full frame 0xA6, 0x77, STOP → RX_DATA=16'h0077, RX_COUNT=1.

Source files
------------

// File: rtl/i2c_slave_rx_if.sv
// Pad-side I2C lines plus the parallel frame handed to the register bank.
// master = bus driver / frame consumer, slave = the receiver block.
interface i2c_slave_rx_if #(
    parameter int NBYTES = 2
);
    localparam int CW = $clog2(NBYTES + 1);

    logic                  SCL_IN;
    logic                  SDA_IN;
    logic                  SDA_OE;
    logic [8*NBYTES-1:0]   RX_DATA;
    logic [CW-1:0]         RX_COUNT;
    logic                  RX_VALID;
    logic                  START_DET;
    logic                  STOP_DET;
    logic                  BUSY;
    logic                  OVERFLOW;

    modport master (
        output SCL_IN, SDA_IN,
        input  SDA_OE, RX_DATA, RX_COUNT, RX_VALID, START_DET, STOP_DET, BUSY, OVERFLOW
    );

    modport slave (
        input  SCL_IN, SDA_IN,
        output SDA_OE, RX_DATA, RX_COUNT, RX_VALID, START_DET, STOP_DET, BUSY, OVERFLOW
    );
endinterface

// File: rtl/i2c_slave_rx.sv
// Oversampling I2C write-only slave: address match, ACK, up to NBYTES bytes per frame; commit SYNC_STAGES+1 CLK after STOP.
// No backpressure: RX_VALID is a one-cycle strobe the register bank must capture.
module i2c_slave_rx #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h53,
    parameter int         NBYTES      = 2,
    parameter int         SYNC_STAGES = 2
) (
    input  logic          CLK,
    input  logic          RSTN,
    i2c_slave_rx_if.slave bus
);
    localparam int              CW      = $clog2(NBYTES + 1);
    localparam int              DW      = 8 * NBYTES;
    localparam logic [CW-1:0]   MAX_CNT = CW'(NBYTES);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
    logic                   r_scl_prev, r_sda_prev;
    state_t                 r_state;
    logic [7:0]             r_shift;
    logic [2:0]             r_bitcnt;
    logic [CW-1:0]          r_bytecnt;
    logic [DW-1:0]          r_buf;
    logic                   r_addr_ok;
    logic                   r_sda_oe;
    logic [DW-1:0]          r_rx_data;
    logic [CW-1:0]          r_rx_count;
    logic                   r_rx_valid, r_start_det, r_stop_det, r_busy, r_overflow;

    logic                   w_scl, w_sda, w_start, w_stop, w_scl_rise, w_scl_fall;
    logic [7:0]             w_byte;
    state_t                 w_nxt_state;
    logic [7:0]             w_nxt_shift;
    logic [2:0]             w_nxt_bitcnt;
    logic [CW-1:0]          w_nxt_bytecnt;
    logic [DW-1:0]          w_nxt_buf;
    logic                   w_nxt_addr_ok, w_nxt_sda_oe;
    logic [DW-1:0]          w_nxt_rx_data;
    logic [CW-1:0]          w_nxt_rx_count;
    logic                   w_nxt_rx_valid, w_nxt_start_det, w_nxt_stop_det, w_nxt_busy, w_nxt_overflow;

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_start    = w_scl && r_sda_prev && !w_sda;
    assign w_stop     = w_scl && !r_sda_prev && w_sda;
    assign w_scl_rise = !r_scl_prev && w_scl;
    assign w_scl_fall = r_scl_prev && !w_scl;
    assign w_byte     = {r_shift[6:0], w_sda};

    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_shift     = r_shift;
        w_nxt_bitcnt    = r_bitcnt;
        w_nxt_bytecnt   = r_bytecnt;
        w_nxt_buf       = r_buf;
        w_nxt_addr_ok   = r_addr_ok;
        w_nxt_sda_oe    = r_sda_oe;
        w_nxt_rx_data   = r_rx_data;
        w_nxt_rx_count  = r_rx_count;
        w_nxt_rx_valid  = 1'b0;
        w_nxt_start_det = 1'b0;
        w_nxt_stop_det  = 1'b0;
        w_nxt_busy      = r_busy;
        w_nxt_overflow  = r_overflow;

        // Bus conditions pre-empt bit sampling; START from any state doubles as repeated START.
        if (w_start) begin
            w_nxt_start_det = 1'b1;
            w_nxt_busy      = 1'b1;
            w_nxt_bitcnt    = 3'd0;
            w_nxt_bytecnt   = '0;
            w_nxt_buf       = '0;
            w_nxt_addr_ok   = 1'b0;
            w_nxt_overflow  = 1'b0;
            w_nxt_sda_oe    = 1'b0;
            w_nxt_state     = ADDR;
        end else if (w_stop) begin
            w_nxt_stop_det = 1'b1;
            w_nxt_busy     = 1'b0;
            w_nxt_sda_oe   = 1'b0;
            w_nxt_addr_ok  = 1'b0;
            w_nxt_state    = IDLE;
            if (r_addr_ok && (r_bytecnt != '0)) begin
                w_nxt_rx_data  = r_buf;
                w_nxt_rx_count = r_bytecnt;
                w_nxt_rx_valid = 1'b1;
            end
        end else begin
            case (r_state)
                ADDR, DATA: begin
                    if (w_scl_rise) begin
                        w_nxt_shift  = w_byte;
                        w_nxt_bitcnt = r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            if (r_state == ADDR) begin
                                if ((w_byte[7:1] == SLAVE_ADDR) && !w_byte[0]) begin
                                    w_nxt_addr_ok = 1'b1;
                                    w_nxt_state   = ADDR_ACK;
                                end else begin
                                    w_nxt_state   = IGNORE;
                                end
                            end else if (r_bytecnt < MAX_CNT) begin
                                for (int k = 0; k < NBYTES; k++) begin
                                    if (r_bytecnt == CW'(k)) w_nxt_buf[8*k +: 8] = w_byte;
                                end
                                w_nxt_bytecnt = r_bytecnt + 1'b1;
                                w_nxt_state   = DATA_ACK;
                            end else begin
                                w_nxt_overflow = 1'b1;
                                w_nxt_state    = IGNORE;
                            end
                        end
                    end
                end
                // First SCL fall opens the ACK window, the next one closes it.
                ADDR_ACK, DATA_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_sda_oe) begin
                            w_nxt_sda_oe = 1'b1;
                        end else begin
                            w_nxt_sda_oe = 1'b0;
                            w_nxt_state  = DATA;
                        end
                    end
                end
                IGNORE:  w_nxt_sda_oe = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_scl_sync  <= '1;
            r_sda_sync  <= '1;
            r_scl_prev  <= 1'b1;
            r_sda_prev  <= 1'b1;
            r_state     <= IDLE;
            r_shift     <= '0;
            r_bitcnt    <= '0;
            r_bytecnt   <= '0;
            r_buf       <= '0;
            r_addr_ok   <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_rx_data   <= '0;
            r_rx_count  <= '0;
            r_rx_valid  <= 1'b0;
            r_start_det <= 1'b0;
            r_stop_det  <= 1'b0;
            r_busy      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_scl_sync  <= {r_scl_sync[SYNC_STAGES-2:0], bus.SCL_IN};
            r_sda_sync  <= {r_sda_sync[SYNC_STAGES-2:0], bus.SDA_IN};
            r_scl_prev  <= w_scl;
            r_sda_prev  <= w_sda;
            r_state     <= w_nxt_state;
            r_shift     <= w_nxt_shift;
            r_bitcnt    <= w_nxt_bitcnt;
            r_bytecnt   <= w_nxt_bytecnt;
            r_buf       <= w_nxt_buf;
            r_addr_ok   <= w_nxt_addr_ok;
            r_sda_oe    <= w_nxt_sda_oe;
            r_rx_data   <= w_nxt_rx_data;
            r_rx_count  <= w_nxt_rx_count;
            r_rx_valid  <= w_nxt_rx_valid;
            r_start_det <= w_nxt_start_det;
            r_stop_det  <= w_nxt_stop_det;
            r_busy      <= w_nxt_busy;
            r_overflow  <= w_nxt_overflow;
        end
    end

    assign bus.SDA_OE    = r_sda_oe;
    assign bus.RX_DATA   = r_rx_data;
    assign bus.RX_COUNT  = r_rx_count;
    assign bus.RX_VALID  = r_rx_valid;
    assign bus.START_DET = r_start_det;
    assign bus.STOP_DET  = r_stop_det;
    assign bus.BUSY      = r_busy;
    assign bus.OVERFLOW  = r_overflow;
endmodule

// File: tb/tb_i2c_slave_rx.sv
// Directed I2C frames against i2c_slave_rx with an open-drain SDA model.
module tb_i2c_slave_rx;
    localparam int NB = 2;
    localparam int Q  = 100;

    logic CLK = 1'b0;
    logic RSTN;
    logic r_scl = 1'b1;
    logic r_sda = 1'b1;

    int n_checks = 0;
    int n_errors = 0;
    int n_valid  = 0;
    int n_start  = 0;
    int n_stop   = 0;
    int n_oe     = 0;
    int cap_data = 0;
    int cap_count = 0;

    i2c_slave_rx_if #(.NBYTES(NB)) bus();

    i2c_slave_rx #(
        .SLAVE_ADDR  (7'h53),
        .NBYTES      (NB),
        .SYNC_STAGES (2)
    ) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus)
    );

    assign bus.SCL_IN = r_scl;
    assign bus.SDA_IN = r_sda & ~bus.SDA_OE;

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (bus.RX_VALID) begin
            n_valid++;
            cap_data  = int'(bus.RX_DATA);
            cap_count = int'(bus.RX_COUNT);
        end
        if (bus.START_DET) n_start++;
        if (bus.STOP_DET)  n_stop++;
        if (bus.SDA_OE)    n_oe++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bit_out(input logic b);
        r_sda = b;
        #Q;
        r_scl = 1'b1;
        #(2*Q);
        r_scl = 1'b0;
        #Q;
    endtask

    task automatic send_byte(input logic [7:0] b, output int ack);
        for (int i = 7; i >= 0; i--) bit_out(b[i]);
        r_sda = 1'b1;
        #Q;
        ack = int'(bus.SDA_OE);
        r_scl = 1'b1;
        #(2*Q);
        r_scl = 1'b0;
        #Q;
    endtask

    task automatic i2c_start();
        r_sda = 1'b1;
        #Q;
        r_scl = 1'b1;
        #Q;
        r_sda = 1'b0;
        #Q;
        r_scl = 1'b0;
        #Q;
    endtask

    task automatic i2c_stop();
        r_sda = 1'b0;
        #Q;
        r_scl = 1'b1;
        #Q;
        r_sda = 1'b1;
        #Q;
    endtask

    initial begin
        int ack;
        int v0, s0, p0, o0;

        RSTN = 1'b1;
        #2;
        RSTN = 1'b0;
        #40;
        check("rst_rx_data", int'(bus.RX_DATA), 0);
        check("rst_rx_count", int'(bus.RX_COUNT), 0);
        check("rst_flags", int'({bus.SDA_OE, bus.RX_VALID, bus.START_DET, bus.STOP_DET, bus.BUSY, bus.OVERFLOW}), 0);
        RSTN = 1'b1;
        #(2*Q);

        // Two-byte write
        v0 = n_valid; s0 = n_start; p0 = n_stop;
        i2c_start();
        check("t1_busy", int'(bus.BUSY), 1);
        send_byte(8'hA6, ack); check("t1_ack_addr", ack, 1);
        send_byte(8'h12, ack); check("t1_ack_d0", ack, 1);
        send_byte(8'h34, ack); check("t1_ack_d1", ack, 1);
        i2c_stop();
        #(2*Q);
        check("t1_valid_cycles", n_valid - v0, 1);
        check("t1_cap_data", cap_data, 32'h3412);
        check("t1_cap_count", cap_count, 2);
        check("t1_start_det", n_start - s0, 1);
        check("t1_stop_det", n_stop - p0, 1);
        check("t1_busy_end", int'(bus.BUSY), 0);

        // Wrong address
        v0 = n_valid; s0 = n_start; p0 = n_stop; o0 = n_oe;
        i2c_start();
        send_byte(8'hA8, ack); check("t2_nack_addr", ack, 0);
        send_byte(8'h55, ack); check("t2_nack_data", ack, 0);
        i2c_stop();
        #(2*Q);
        check("t2_oe_cycles", n_oe - o0, 0);
        check("t2_valid_cycles", n_valid - v0, 0);
        check("t2_rx_data", int'(bus.RX_DATA), 32'h3412);
        check("t2_start_det", n_start - s0, 1);
        check("t2_stop_det", n_stop - p0, 1);

        // Read request
        v0 = n_valid;
        i2c_start();
        send_byte(8'hA7, ack); check("t3_nack_read", ack, 0);
        i2c_stop();
        #(2*Q);
        check("t3_valid_cycles", n_valid - v0, 0);

        // Overflow
        v0 = n_valid;
        i2c_start();
        send_byte(8'hA6, ack); check("t4_ack_addr", ack, 1);
        send_byte(8'h01, ack); check("t4_ack_d0", ack, 1);
        send_byte(8'h02, ack); check("t4_ack_d1", ack, 1);
        send_byte(8'h03, ack); check("t4_nack_d2", ack, 0);
        check("t4_overflow", int'(bus.OVERFLOW), 1);
        i2c_stop();
        #(2*Q);
        check("t4_valid_cycles", n_valid - v0, 1);
        check("t4_rx_data", int'(bus.RX_DATA), 32'h0201);
        check("t4_rx_count", int'(bus.RX_COUNT), 2);
        check("t4_overflow_sticky", int'(bus.OVERFLOW), 1);

        // Repeated START discards the first data byte
        v0 = n_valid; s0 = n_start;
        i2c_start();
        check("t5_overflow_clr", int'(bus.OVERFLOW), 0);
        send_byte(8'hA6, ack);
        send_byte(8'hAA, ack);
        i2c_start();
        send_byte(8'hA6, ack); check("t5_ack_addr2", ack, 1);
        send_byte(8'h5C, ack); check("t5_ack_d0", ack, 1);
        i2c_stop();
        #(2*Q);
        check("t5_start_det", n_start - s0, 2);
        check("t5_valid_cycles", n_valid - v0, 1);
        check("t5_rx_data", int'(bus.RX_DATA), 32'h005C);
        check("t5_rx_count", int'(bus.RX_COUNT), 1);

        // Reset during the 4th data bit
        v0 = n_valid;
        i2c_start();
        send_byte(8'hA6, ack);
        bit_out(1'b0);
        bit_out(1'b1);
        bit_out(1'b1);
        r_sda = 1'b1;
        #Q;
        r_scl = 1'b1;
        #Q;
        RSTN = 1'b0;
        #1;
        check("t6_rst_busy", int'(bus.BUSY), 0);
        check("t6_rst_rx_data", int'(bus.RX_DATA), 0);
        check("t6_rst_rx_count", int'(bus.RX_COUNT), 0);
        check("t6_rst_oe", int'(bus.SDA_OE), 0);
        #Q;
        r_scl = 1'b0;
        #Q;
        r_sda = 1'b1;
        #Q;
        r_scl = 1'b1;
        #Q;
        RSTN = 1'b1;
        #(2*Q);
        check("t6_idle_busy", int'(bus.BUSY), 0);
        check("t6_no_valid_abort", n_valid - v0, 0);
        i2c_start();
        send_byte(8'hA6, ack); check("t6_ack_addr", ack, 1);
        send_byte(8'h77, ack); check("t6_ack_d0", ack, 1);
        i2c_stop();
        #(2*Q);
        check("t6_valid_cycles", n_valid - v0, 1);
        check("t6_rx_data", int'(bus.RX_DATA), 32'h0077);
        check("t6_rx_count", int'(bus.RX_COUNT), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
